// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the byte-wide sram controller between a
// primary (A) and secondary (B) requester, one access at a time.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter bit ROUND_ROBIN   = 1'b0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        prog,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [18:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [18:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [18:0] address,
  output logic [7:0]  indata,
  output logic        load,
  output logic        store,
  input  logic [7:0]  outdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    ACK
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [18:0] address_n;
  logic [7:0]  indata_n;
  logic        load_n, store_n;
  logic [1:0]  grant_n;
  logic        busy_n;
  logic        a_ack_n, b_ack_n;
  logic [7:0]  a_rdata_n, b_rdata_n;
  logic        we_q, we_n;
  logic        rr_b, rr_b_n;
  logic        pick_b;

  // rr_b set means B holds priority on the next contention
  always_comb begin
    pick_b = b_req && (!a_req || (ROUND_ROBIN && rr_b));
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    address_n = address;
    indata_n  = indata;
    load_n    = load;
    store_n   = store;
    grant_n   = grant;
    busy_n    = busy;
    a_ack_n   = a_ack;
    b_ack_n   = b_ack;
    a_rdata_n = a_rdata;
    b_rdata_n = b_rdata;
    we_n      = we_q;
    rr_b_n    = rr_b;
    unique case (state)
      IDLE: begin
        load_n  = 1'b0;
        store_n = 1'b0;
        if (!prog && (a_req || b_req)) begin
          state_n   = ACCESS;
          cnt_n     = CNT_INIT;
          address_n = pick_b ? b_addr : a_addr;
          indata_n  = pick_b ? b_wdata : a_wdata;
          we_n      = pick_b ? b_we : a_we;
          store_n   = we_n;
          load_n    = !we_n;
          grant_n   = pick_b ? 2'b10 : 2'b01;
          busy_n    = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          load_n  = 1'b0;
          store_n = 1'b0;
          state_n = CAPTURE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        state_n = ACK;
        a_ack_n = grant[0];
        b_ack_n = grant[1];
        if (!we_q) begin
          if (grant[0]) a_rdata_n = outdata;
          if (grant[1]) b_rdata_n = outdata;
        end
      end
      ACK: begin
        state_n = IDLE;
        a_ack_n = 1'b0;
        b_ack_n = 1'b0;
        grant_n = 2'b00;
        busy_n  = 1'b0;
        if (ROUND_ROBIN) rr_b_n = grant[0];
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      address <= '0;
      indata  <= '0;
      load    <= 1'b0;
      store   <= 1'b0;
      grant   <= 2'b00;
      busy    <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      we_q    <= 1'b0;
      rr_b    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      address <= address_n;
      indata  <= indata_n;
      load    <= load_n;
      store   <= store_n;
      grant   <= grant_n;
      busy    <= busy_n;
      a_ack   <= a_ack_n;
      b_ack   <= b_ack_n;
      a_rdata <= a_rdata_n;
      b_rdata <= b_rdata_n;
      we_q    <= we_n;
      rr_b    <= rr_b_n;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: three arbiter instances (fixed prio, round robin,
// long access) against a 2-register sram model, scoreboard checked.
module tb_sram_arbiter;

  typedef struct {
    bit          port;
    bit          we;
    bit          chk;
    logic [7:0]  data;
    logic [18:0] addr;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]        resetn, prog;
  logic [2:0]        a_req, a_we, a_ack;
  logic [2:0]        b_req, b_we, b_ack;
  logic [2:0]        load, store, busy;
  logic [2:0][18:0]  a_addr, b_addr, address;
  logic [2:0][7:0]   a_wdata, b_wdata, a_rdata, b_rdata, indata;
  logic [2:0][1:0]   grant;
  logic [2:0]        pl_en;
  logic [18:0]       pl_addr;
  logic [7:0]        pl_data;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [7:0] mem [0:(1<<19)-1];
    logic [7:0] pipe;
    logic [7:0] odata;

    sram_arbiter #(
      .ACCESS_CYCLES(g == 2 ? 4 : 2),
      .ROUND_ROBIN  (g == 1)
    ) u_dut (
      .clock  (clock),
      .resetn (resetn[g]),
      .prog   (prog[g]),
      .a_req  (a_req[g]),
      .a_we   (a_we[g]),
      .a_addr (a_addr[g]),
      .a_wdata(a_wdata[g]),
      .a_ack  (a_ack[g]),
      .a_rdata(a_rdata[g]),
      .b_req  (b_req[g]),
      .b_we   (b_we[g]),
      .b_addr (b_addr[g]),
      .b_wdata(b_wdata[g]),
      .b_ack  (b_ack[g]),
      .b_rdata(b_rdata[g]),
      .address(address[g]),
      .indata (indata[g]),
      .load   (load[g]),
      .store  (store[g]),
      .outdata(odata),
      .grant  (grant[g]),
      .busy   (busy[g])
    );

    // sram model: write on store, read data two registers behind address
    always @(posedge clock) begin
      if (pl_en[g]) mem[pl_addr] <= pl_data;
      else if (store[g] && !prog[g]) mem[address[g]] <= indata[g];
      pipe  <= mem[address[g]];
      odata <= pipe;
    end
  end

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_gnt [3];
  int         ld_n [3];
  int         st_n [3];
  int         a_left [3];
  int         b_left [3];
  bit         busy_q [3];
  bit         gap_chk [3];
  logic [7:0] last_rd [3][2];
  bit         rd_known [3][2];
  exp_t       exq [3][$];

  function automatic int ac(int g);
    return (g == 2) ? 4 : 2;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic on_ack(int g);
    exp_t       e;
    bit         p;
    logic [7:0] rd;
    p = b_ack[g];
    if (exq[g].size() == 0) begin
      check("spurious_ack", {30'd0, b_ack[g], a_ack[g]}, 0);
      return;
    end
    e = exq[g].pop_front();
    check("ack_port", 32'(p), 32'(e.port));
    check("ack_latency", cyc - last_gnt[g], ac(g) + 1);
    check("cmd_cycles", e.we ? st_n[g] : ld_n[g], ac(g));
    check("cmd_other", e.we ? ld_n[g] : st_n[g], 0);
    rd = p ? b_rdata[g] : a_rdata[g];
    if (e.we) begin
      if (rd_known[g][p]) check("wr_keeps_rdata", rd, last_rd[g][p]);
    end else if (e.chk) begin
      check("rdata", rd, e.data);
      last_rd[g][p]  = e.data;
      rd_known[g][p] = 1'b1;
    end else begin
      rd_known[g][p] = 1'b0;
    end
    if (!p) begin
      a_left[g]--;
      if (a_left[g] <= 0) a_req[g] = 1'b0;
    end else begin
      b_left[g]--;
      if (b_left[g] <= 0) b_req[g] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (busy[g] && !busy_q[g]) begin
        if (exq[g].size() == 0) begin
          check("spurious_grant", grant[g], 0);
        end else begin
          check("grant", grant[g],
                exq[g][0].port ? 2'b10 : 2'b01);
          check("address", address[g], exq[g][0].addr);
          if (gap_chk[g] && last_gnt[g] >= 0)
            check("grant_gap", cyc - last_gnt[g], ac(g) + 3);
        end
        last_gnt[g] = cyc;
        ld_n[g]     = 0;
        st_n[g]     = 0;
      end
      busy_q[g] = busy[g];
      if (load[g]) ld_n[g]++;
      if (store[g]) st_n[g]++;
      check("exclusive", {30'd0, a_ack[g] & b_ack[g],
                          load[g] & store[g]}, 0);
      if (a_ack[g] || b_ack[g]) on_ack(g);
    end
  endtask

  task automatic push(int g, bit p, bit we, logic [18:0] addr,
                      logic [7:0] d, bit chk);
    exp_t e;
    e.port = p;
    e.we   = we;
    e.chk  = chk;
    e.data = d;
    e.addr = addr;
    exq[g].push_back(e);
  endtask

  task automatic drive(int g, bit p, bit we, logic [18:0] addr,
                       logic [7:0] wd, int n);
    if (!p) begin
      a_we[g]    = we;
      a_addr[g]  = addr;
      a_wdata[g] = wd;
      a_left[g]  = n;
      a_req[g]   = 1'b1;
    end else begin
      b_we[g]    = we;
      b_addr[g]  = addr;
      b_wdata[g] = wd;
      b_left[g]  = n;
      b_req[g]   = 1'b1;
    end
  endtask

  task automatic preload(int g, logic [18:0] addr, logic [7:0] d);
    pl_en[g] = 1'b1;
    pl_addr  = addr;
    pl_data  = d;
    tick();
    pl_en[g] = 1'b0;
  endtask

  task automatic wait_done(int g, int max);
    int n;
    n = 0;
    while (exq[g].size() != 0 && n < max) begin
      tick();
      n++;
    end
    check("drained", exq[g].size(), 0);
    exq[g].delete();
    a_req[g] = 1'b0;
    b_req[g] = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_reset(int g);
    check("rst_address", address[g], 0);
    check("rst_indata", indata[g], 0);
    check("rst_load", load[g], 0);
    check("rst_store", store[g], 0);
    check("rst_a_ack", a_ack[g], 0);
    check("rst_b_ack", b_ack[g], 0);
    check("rst_a_rdata", a_rdata[g], 0);
    check("rst_b_rdata", b_rdata[g], 0);
    check("rst_busy", busy[g], 0);
    check("rst_grant", grant[g], 0);
  endtask

  initial begin
    resetn  = '0;
    prog    = '0;
    a_req   = '0;
    a_we    = '0;
    a_addr  = '0;
    a_wdata = '0;
    b_req   = '0;
    b_we    = '0;
    b_addr  = '0;
    b_wdata = '0;
    pl_en   = '0;
    pl_addr = '0;
    pl_data = '0;
    for (int g = 0; g < 3; g++) begin
      last_gnt[g] = -1;
      ld_n[g]     = 0;
      st_n[g]     = 0;
      a_left[g]   = 0;
      b_left[g]   = 0;
      busy_q[g]   = 1'b0;
      gap_chk[g]  = 1'b0;
      for (int p = 0; p < 2; p++) begin
        last_rd[g][p]  = 8'h00;
        rd_known[g][p] = 1'b1;
      end
    end
    repeat (2) tick();
    for (int g = 0; g < 3; g++) chk_reset(g);
    resetn = '1;
    tick();

    // single read on A
    preload(0, 19'h00123, 8'h5A);
    push(0, 0, 0, 19'h00123, 8'h5A, 1);
    drive(0, 0, 0, 19'h00123, 8'h00, 1);
    wait_done(0, 20);
    check("a_rdata_hold", a_rdata[0], 8'h5A);

    // write then read on B at the top address
    push(0, 1, 1, 19'h7FFFF, 8'hC3, 0);
    drive(0, 1, 1, 19'h7FFFF, 8'hC3, 1);
    wait_done(0, 20);
    push(0, 1, 0, 19'h7FFFF, 8'hC3, 1);
    drive(0, 1, 0, 19'h7FFFF, 8'h00, 1);
    wait_done(0, 20);

    // fixed priority contention
    preload(0, 19'h00010, 8'h11);
    preload(0, 19'h00020, 8'h22);
    repeat (4) push(0, 0, 0, 19'h00010, 8'h11, 1);
    repeat (4) push(0, 1, 0, 19'h00020, 8'h22, 1);
    drive(0, 0, 0, 19'h00010, 8'h00, 4);
    drive(0, 1, 0, 19'h00020, 8'h00, 4);
    wait_done(0, 80);

    // prog raised during an A read
    preload(0, 19'h00400, 8'h77);
    push(0, 0, 0, 19'h00300, 8'h00, 0);
    drive(0, 0, 0, 19'h00300, 8'h00, 1);
    tick();
    check("prog_a_grant", grant[0], 2'b01);
    tick();
    prog[0] = 1'b1;
    push(0, 1, 0, 19'h00400, 8'h77, 1);
    drive(0, 1, 0, 19'h00400, 8'h00, 1);
    repeat (3) tick();
    repeat (6) begin
      tick();
      check("prog_hold",
            {27'd0, busy[0], grant[0], load[0], store[0]}, 0);
    end
    prog[0] = 1'b0;
    tick();
    check("prog_resume", grant[0], 2'b10);
    wait_done(0, 20);

    // round robin contention
    preload(1, 19'h00011, 8'hA1);
    preload(1, 19'h00022, 8'hB2);
    gap_chk[1]  = 1'b1;
    last_gnt[1] = -1;
    push(1, 0, 0, 19'h00011, 8'hA1, 1);
    push(1, 1, 0, 19'h00022, 8'hB2, 1);
    push(1, 0, 0, 19'h00011, 8'hA1, 1);
    push(1, 1, 0, 19'h00022, 8'hB2, 1);
    drive(1, 0, 0, 19'h00011, 8'h00, 2);
    drive(1, 1, 0, 19'h00022, 8'h00, 2);
    wait_done(1, 60);
    gap_chk[1] = 1'b0;

    // long access, then reset in the middle of one
    preload(2, 19'h00500, 8'hA5);
    preload(2, 19'h00501, 8'h3C);
    push(2, 0, 0, 19'h00500, 8'hA5, 1);
    drive(2, 0, 0, 19'h00500, 8'h00, 1);
    wait_done(2, 30);
    drive(2, 0, 0, 19'h00501, 8'h00, 1);
    push(2, 0, 0, 19'h00501, 8'h3C, 1);
    tick();
    tick();
    check("pre_reset_load", load[2], 1);
    resetn[2] = 1'b0;
    #1;
    chk_reset(2);
    exq[2].delete();
    a_req[2]  = 1'b0;
    a_left[2] = 0;
    last_rd[2][0] = 8'h00;
    last_rd[2][1] = 8'h00;
    rd_known[2][0] = 1'b1;
    rd_known[2][1] = 1'b1;
    repeat (6) begin
      tick();
      check("reset_quiet", {30'd0, busy[2], a_ack[2]}, 0);
    end
    resetn[2] = 1'b1;
    tick();
    push(2, 0, 0, 19'h00501, 8'h3C, 1);
    drive(2, 0, 0, 19'h00501, 8'h00, 1);
    wait_done(2, 30);
    check("post_reset_rdata", a_rdata[2], 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter sharing the byte-wide `sram` controller between a primary requester (port A, CPU) and a secondary requester (port B, video/DMA). It accepts one request at a time, drives `sram`'s `address`/`indata`/`load`/`store` for a fixed access window, captures `outdata`, and returns a one-cycle acknowledge to the granted port. During UART programming (`prog`), it grants no new requests.

## Interface
- `ACCESS_CYCLES`, default 2: cycles that `load`/`store` are held per access; legal range 2..15.
- `ROUND_ROBIN`, default 0: 0 = port A has fixed priority; 1 = alternate on contention.
- `clock` in 1: system clock; same clock as `sram`.
- `resetn` in 1: reset, asynchronous and active-low.
- `prog` in 1: programming mode; same signal fed to `sram.prog`.
- `a_req` in 1: port A request; held high until `a_ack`.
- `a_we` in 1: port A write (1) or read (0).
- `a_addr` in 19: port A byte address.
- `a_wdata` in 8: port A write data.
- `a_ack` out 1: one-cycle completion pulse for port A.
- `a_rdata` out 8: port A read data; valid when `a_ack`=1; held until the next port A read completes.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as port A, for port B.
- `address` out 19: to `sram.address`.
- `indata` out 8: to `sram.indata`.
- `load` out 1: to `sram.load`.
- `store` out 1: to `sram.store`.
- `outdata` in 8: from `sram.outdata`.
- `grant` out 2: one-hot owner of the current access ({B,A}); 00 when idle.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values:
  - 0: `address`, `indata`, `load`, `store`, `a_ack`, `b_ack`, `a_rdata`, `b_rdata`, `busy`.
  - `grant` = 00; round-robin pointer = port A; state = IDLE.
- States are IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE.
- **IDLE**:
  - When `prog`=0 and any request is high, choose the winner, then register `address`, `indata`, and `store`=we, `load`=~we from the winner.
  - Set `grant` and `busy`, load the counter with `ACCESS_CYCLES`-1, and go to ACCESS.
  - When `prog`=1, stay in IDLE. `load` = `store` = 0.
- **ACCESS**:
  - Hold the command stable and decrement the counter.
  - At counter 0, clear `load`/`store` and go to CAPTURE.
  - Request inputs are ignored; the command was latched at grant.
- **CAPTURE**:
  - `outdata` is valid (the `sram` pipeline is 2 registers).
  - At the end of the cycle, on a read, register `outdata` into the granted port's `rdata` and set its `ack`. Go to ACK.
- **ACK**:
  - `ack` is high for exactly this cycle. Clear `ack`, `grant` and `busy`; go to IDLE.
  - If `ROUND_ROBIN`=1, point priority at the other port.
- Arbitration:
  - With a single requester, that requester wins.
  - When both request with `ROUND_ROBIN`=0, A wins.
  - When both request with `ROUND_ROBIN`=1, the port that did not win last wins.
  - After reset with `ROUND_ROBIN`=1, A wins the first contention.
- Write completion: `ack` pulses and `rdata` is unchanged.
- Requester rule: clear `req` on the edge that samples `ack`=1. A `req` still high in IDLE is treated as a new request.
- `prog` rising mid-access:
  - The access runs to completion and `ack` is still issued.
  - Read data is undefined, because `sram` ignores the arbiter's command while `prog`=1.
- `prog` falling: arbitration resumes in the next IDLE cycle.
- Reset mid-access: all outputs return to their reset values at once. No `ack` is issued for the aborted access.
- Addresses pass through unmodified, full 19 bits; there is no wrap logic.

## Timing
- Grant edge = the IDLE clock edge at which a request is sampled.
- `load`/`store`/`address` are valid from that edge for `ACCESS_CYCLES` cycles.
- `ack` rises `ACCESS_CYCLES`+1 edges after the grant edge; this is 3 edges at the default.
- Minimum spacing between grant edges is `ACCESS_CYCLES`+3 cycles; this is 5 at the default.
- The IDLE cycle between accesses is mandatory.
- `a_ack` and `b_ack` are never high together. `load` and `store` are never high together.

## Test plan
- Single read, A:
  - Preload SRAM 0x00123 = 0x5A. Raise `a_req` with `a_we`=0 and `a_addr`=0x00123.
  - Required: `load`=1 for 2 cycles, `a_ack` 3 edges after grant, `a_rdata`=0x5A, `b_ack` stays 0.
- Write-then-read, B:
  - Issue `b_we`=1, `b_addr`=0x7FFFF, `b_wdata`=0xC3. Then issue a read of the same address.
  - Required: `store` pulses for 2 cycles, `b_rdata`=0xC3, `b_rdata` unchanged across the write `ack`.
- Contention, `ROUND_ROBIN`=0:
  - Hold A and B requesting for 4 accesses each.
  - Required: A is served each time until it drops; B is served only after.
- Contention, `ROUND_ROBIN`=1:
  - Hold A and B requesting continuously.
  - Required: `grant` sequence is 01, 10, 01, 10; each grant edge is 5 cycles apart.
- `prog` interlock:
  - Raise `prog` during ACCESS of an A read.
  - Required: `a_ack` still issued. While `prog`=1, `b_req` is not granted and `load`/`store` stay 0. After `prog` falls, B is granted in the next IDLE cycle.
- Reset mid-access:
  - Assert `resetn`=0 in ACCESS with `ACCESS_CYCLES`=4.
  - Required: all outputs are at their reset values immediately and no `ack` is issued. After release, a new A request completes normally.
